pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pmem_responder.sv | 122 ++++++++++++
 tb/tb_pmem_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Fixed-latency line memory answering a cache's pmem_read/pmem_write with a one-cycle pmem_resp.
// Define PMEM_PROTO_CHECK_EN to add the sticky proto_err protocol monitor output.
module pmem_responder #(
  parameter int LATENCY = 4,
  parameter int LINES   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp
`ifdef PMEM_PROTO_CHECK_EN
  ,
  output logic         proto_err
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam logic [7:0] LAT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_next;
  logic [7:0]         count, count_next;
  logic [IDX_W-1:0]   line_reg;
  logic               write_reg;
  logic [127:0]       wdata_reg;
  logic [127:0]       mem [LINES];

  logic               accept;
  logic [IDX_W-1:0]   req_line;
  logic [IDX_W-1:0]   rd_line;
  logic               read_op;
  logic               load_rdata;

  assign accept   = (state == IDLE) && (pmem_read || pmem_write);
  assign req_line = pmem_address[IDX_W+3:4];

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (LATENCY > 1) ? BUSY : RESP;
          count_next = LAT_LOAD;
        end
      end
      BUSY: begin
        if (count == 8'd0) state_next = RESP;
        else               count_next = count - 8'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Simultaneous read and write is treated as a read, so only a pure write is recorded.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_reg  <= req_line;
      write_reg <= pmem_write && !pmem_read;
      wdata_reg <= pmem_wdata;
    end
  end

  // With LATENCY==1 the RAM is read on the acceptance edge, before line_reg is loaded.
  assign rd_line    = (state == IDLE) ? req_line : line_reg;
  assign read_op    = (state == IDLE) ? pmem_read : !write_reg;
  assign load_rdata = (state_next == RESP) && read_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pmem_rdata <= 128'h0;
    else if (load_rdata) pmem_rdata <= mem[rd_line];
  end

  // Storage is never reset; the write lands on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (state == RESP && write_reg) mem[line_reg] <= wdata_reg;
  end

  assign pmem_resp = (state == RESP);

`ifdef PMEM_PROTO_CHECK_EN
  logic        prev_read, prev_write;
  logic [15:0] prev_address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_read    <= 1'b0;
      prev_write   <= 1'b0;
      prev_address <= 16'h0;
      proto_err    <= 1'b0;
    end else begin
      prev_read    <= pmem_read;
      prev_write   <= pmem_write;
      prev_address <= pmem_address;
      if ((accept && pmem_read && pmem_write) ||
          (state == BUSY && (pmem_read != prev_read || pmem_write != prev_write ||
                             pmem_address != prev_address)))
        proto_err <= 1'b1;
    end
  end
`else
  logic unused_address;
  assign unused_address = ^pmem_address;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized self-checking bench for pmem_responder against an array-based line model.
// Also exercises a LATENCY=1 instance with a continuously held read.
module tb_pmem_responder;

  localparam int LAT   = 4;
  localparam int LINES = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pmem_read = 1'b0, pmem_write = 1'b0;
  logic [15:0]  pmem_address = 16'h0;
  logic [127:0] pmem_wdata = 128'h0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         read1 = 1'b0;
  logic [127:0] unused_rdata1;
  logic         resp1;
`ifdef PMEM_PROTO_CHECK_EN
  logic         proto_err;
  logic         unused_err1;
`endif

  pmem_responder #(.LATENCY(LAT), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef PMEM_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  pmem_responder #(.LATENCY(1), .LINES(LINES)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(read1), .pmem_write(1'b0),
    .pmem_address(16'h0040), .pmem_wdata(128'h0),
    .pmem_rdata(unused_rdata1), .pmem_resp(resp1)
`ifdef PMEM_PROTO_CHECK_EN
    , .proto_err(unused_err1)
`endif
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [127:0] ref_mem [LINES];
  logic [127:0] exp_rdata = 128'h0;
  logic         exp_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction, starting and ending on a falling edge with the responder idle.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] wd, input logic glitch);
    int n;
    int idx;
    logic got;
    idx = int'(addr[9:4]);
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (glitch && n == 1) pmem_address = addr ^ 16'h0150;
      if (n < LAT) pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      if (pmem_resp) got = 1'b1;
    end
    chk("latency", 128'(n), 128'(LAT));
    if (rd) exp_rdata = ref_mem[idx];
    chk("rdata", pmem_rdata, exp_rdata);
    if (rd && wr) exp_err = 1'b1;
    if (glitch) exp_err = 1'b1;
    pmem_read = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    chk("resp_pulse", 128'(pmem_resp), 128'(0));
    chk("rdata_hold", pmem_rdata, exp_rdata);
    if (wr && !rd) ref_mem[idx] = wd;
`ifdef PMEM_PROTO_CHECK_EN
    chk("proto_err", 128'(proto_err), 128'(exp_err));
`endif
  endtask

  initial begin
    logic [127:0] d;
    logic [15:0]  a;
    int           r;
    logic         prev;

    #3 rst = 1'b1;
    #1;
    chk("rst_resp", 128'(pmem_resp), 128'(0));
    chk("rst_rdata", pmem_rdata, 128'h0);
`ifdef PMEM_PROTO_CHECK_EN
    chk("rst_err", 128'(proto_err), 128'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // Fill every line so all later reads have a known answer.
    for (int i = 0; i < LINES; i++)
      txn(1'b0, 1'b1, 16'(i << 4), {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    txn(1'b0, 1'b1, 16'h1230, {8{16'hA5A5}}, 1'b0);
    txn(1'b1, 1'b0, 16'h1238, 128'h0, 1'b0);
    chk("a5a5_read", pmem_rdata, {8{16'hA5A5}});

    d = {$urandom, $urandom, $urandom, $urandom};
    txn(1'b0, 1'b1, 16'h0010, d, 1'b0);
    txn(1'b1, 1'b0, 16'h0410, 128'h0, 1'b0);
    chk("alias_read", pmem_rdata, d);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      a = 16'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (r < 4)       txn(1'b1, 1'b0, a, d, 1'b0);
      else if (r < 8)  txn(1'b0, 1'b1, a, d, 1'b0);
      else if (r == 8) txn(1'b1, 1'b1, a, d, 1'b0);
      else             txn(1'b1, 1'b0, a, d, 1'b1);
    end

    // Reset two cycles into a write: no response, line keeps old contents.
    pmem_write = 1'b1; pmem_address = 16'h0020; pmem_wdata = ~ref_mem[2];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; pmem_write = 1'b0;
    #1;
    chk("midrst_rdata", pmem_rdata, 128'h0);
    exp_rdata = 128'h0; exp_err = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_resp", 128'(pmem_resp), 128'(0));
    end
`ifdef PMEM_PROTO_CHECK_EN
    chk("midrst_err", 128'(proto_err), 128'(0));
`endif
    txn(1'b1, 1'b0, 16'h0020, 128'h0, 1'b0);
    txn(1'b1, 1'b1, 16'h0030, 128'h1, 1'b0);

    // LATENCY=1 with read held: response alternates, never two in a row.
    read1 = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("lat1_resp", 128'(resp1), 128'(i % 2 == 0));
      if (i > 0) chk("lat1_noconsec", 128'(prev && resp1), 128'(0));
      prev = resp1;
    end
    read1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
